// File: rtl/iterative_unrotator.sv
// Recovers a barrel-rotated word by undoing the rotation one bit per clock.
// A start/busy/done handshake frames each operation; data_out holds the last result.
module iterative_unrotator #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             lr,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state, w_state_next;
  logic [WIDTH-1:0]   r_work, w_work_next;
  logic               r_dir, w_dir_next;
  logic [AMT_W-1:0]   r_cnt, w_cnt_next;
  logic [WIDTH-1:0]   r_data_out, w_data_out_next;
  logic [WIDTH-1:0]   w_rot;

  // Undo direction: an original left rotation is reversed by rotating right.
  assign w_rot = r_dir ? {r_work[0], r_work[WIDTH-1:1]}
                       : {r_work[WIDTH-2:0], r_work[WIDTH-1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_work     <= '0;
      r_dir      <= 1'b0;
      r_cnt      <= '0;
      r_data_out <= '0;
    end else begin
      r_state    <= w_state_next;
      r_work     <= w_work_next;
      r_dir      <= w_dir_next;
      r_cnt      <= w_cnt_next;
      r_data_out <= w_data_out_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_work_next     = r_work;
    w_dir_next      = r_dir;
    w_cnt_next      = r_cnt;
    w_data_out_next = r_data_out;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_work_next = data_in;
          w_dir_next  = lr;
          w_cnt_next  = amount;
          if (amount != '0) begin
            w_state_next = S_SHIFT;
          end else begin
            w_state_next    = S_DONE;
            w_data_out_next = data_in;
          end
        end
      end
      S_SHIFT: begin
        w_work_next = w_rot;
        w_cnt_next  = r_cnt - AMT_W'(1);
        if (r_cnt == AMT_W'(1)) begin
          w_data_out_next = w_rot;
          w_state_next    = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign busy     = (r_state == S_SHIFT);
  assign done     = (r_state == S_DONE);
  assign data_out = r_data_out;

endmodule
